// File: rtl/sd_audio_out_if.sv
`default_nettype none
// ============================================================================
// Module   : sd_audio_out_if
// Purpose  : Sample stream handshake between the sound synthesis block
//            (master) and the audio output stage (slave).
// Signals  : s_data  - signed sample, two's complement, SAMPLE_W bits
//            s_valid - s_data holds a sample
//            s_ready - consumer can accept a sample this cycle
// Revision : 1.0 - initial release
// ============================================================================
interface sd_audio_out_if #(
    parameter int SAMPLE_W = 12
) ();
    logic signed [SAMPLE_W-1:0] s_data;
    logic                       s_valid;
    logic                       s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface
`default_nettype wire

// File: rtl/sd_audio_out.sv
`default_nettype none
// ============================================================================
// Module   : sd_audio_out
// Purpose  : Audio output stage. Requests samples at a fixed rate, holds the
//            last sample on underrun, applies a shift-based soft ramp on
//            reset/mute and converts to a 1-bit stream with a first-order
//            sigma-delta modulator.
// Ports    : clk      - clock
//            rst_n    - synchronous active-low reset
//            s_if     - sample stream (slave side: s_data, s_valid, s_ready)
//            mute     - level, 1 = ramp to silence and hold
//            snd_out  - registered sigma-delta bitstream
//            underrun - one-cycle pulse, a tick found no sample this period
//            active   - high while in the RUN state
// Options  : SD_AUDIO_DITHER_EN - when defined, a 16-bit Galois LFSR
//            (seed 0xACE1, taps 0xB400) feeds the modulator carry-in.
// Revision : 1.0 - initial release
// ============================================================================
module sd_audio_out #(
    parameter int SAMPLE_W      = 12,
    parameter int SAMPLE_PERIOD = 1024,
    parameter int RAMP_DIV      = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    sd_audio_out_if.slave s_if,
    input  logic          mute,
    output logic          snd_out,
    output logic          underrun,
    output logic          active
);

    localparam int CNT_W   = $clog2(SAMPLE_PERIOD);
    localparam int RAMP_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int SHIFT_W = $clog2(SAMPLE_W + 1);

    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [RAMP_W-1:0]  RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
    localparam logic [SHIFT_W-1:0] SHIFT_OFF = SHIFT_W'(SAMPLE_W);
    localparam logic [SHIFT_W-1:0] SHIFT_ONE = SHIFT_W'(1);
    localparam logic [SHIFT_W-1:0] SHIFT_PRE = SHIFT_W'(SAMPLE_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_RUN       = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_MUTED     = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]           cnt_q,          cnt_d;
    logic                       s_ready_q,      s_ready_d;
    logic signed [SAMPLE_W-1:0] pending_q,      pending_d;
    logic                       pending_full_q, pending_full_d;
    logic signed [SAMPLE_W-1:0] cur_sample_q,   cur_sample_d;
    logic                       underrun_q,     underrun_d;
    state_t                     state_q,        state_d;
    logic [RAMP_W-1:0]          ramp_cnt_q,     ramp_cnt_d;
    logic [SHIFT_W-1:0]         shift_q,        shift_d;
    logic [SAMPLE_W-1:0]        acc_q,          acc_d;
    logic                       c_q,            c_d;
    logic                       snd_out_q,      snd_out_d;

    // Combinational helpers
    logic                       tick;
    logic                       xfer;
    logic                       ramp_wrap;
    logic signed [SAMPLE_W-1:0] shifted;
    logic signed [SAMPLE_W-1:0] x_eff;
    logic [SAMPLE_W-1:0]        u;
    logic [SAMPLE_W:0]          sum;
    logic                       cin;

    // ------------------------------------------------------------------
    // Optional dither source for the modulator carry-in
    // ------------------------------------------------------------------
`ifdef SD_AUDIO_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q >> 1;
        if (lfsr_q[0]) begin
            lfsr_d = (lfsr_q >> 1) ^ 16'hB400;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign cin = lfsr_q[0];
`else
    assign cin = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sample pacing and handshake
    // ------------------------------------------------------------------
    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        xfer  = s_if.s_valid & s_ready_q;

        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        cur_sample_d   = cur_sample_q;
        underrun_d     = 1'b0;

        if (tick) begin
            if (pending_full_q) begin
                cur_sample_d   = pending_q;
                pending_full_d = 1'b0;
            end else if (xfer) begin
                // Arrived exactly on the tick: use it directly, pending
                // stays empty and this still counts as on time.
                cur_sample_d = s_if.s_data;
            end else begin
                underrun_d = 1'b1;
            end
        end else if (xfer) begin
            pending_d      = s_if.s_data;
            pending_full_d = 1'b1;
        end

        // s_ready is a registered copy of "pending will be empty".
        s_ready_d = ~pending_full_d;
    end

    // ------------------------------------------------------------------
    // Ramp FSM: advances only on sample ticks
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        ramp_cnt_d = ramp_cnt_q;
        ramp_wrap  = (ramp_cnt_q == RAMP_LAST);

        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    ramp_cnt_d = '0;
                    state_d    = mute ? ST_MUTED : ST_RAMP_UP;
                end
                ST_RAMP_UP: begin
                    if (mute) begin
                        state_d    = ST_RAMP_DOWN;
                        ramp_cnt_d = '0;
                    end else if (shift_q == '0) begin
                        // Re-entered with nothing left to ramp.
                        state_d    = ST_RUN;
                        ramp_cnt_d = '0;
                    end else if (ramp_wrap) begin
                        shift_d    = shift_q - SHIFT_ONE;
                        ramp_cnt_d = '0;
                        if (shift_q == SHIFT_ONE) begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        ramp_cnt_d = ramp_cnt_q + RAMP_W'(1);
                    end
                end
                ST_RUN: begin
                    shift_d = '0;
                    if (mute) begin
                        state_d    = ST_RAMP_DOWN;
                        ramp_cnt_d = '0;
                    end
                end
                ST_RAMP_DOWN: begin
                    if (!mute) begin
                        state_d    = ST_RAMP_UP;
                        ramp_cnt_d = '0;
                    end else if (shift_q == SHIFT_OFF) begin
                        state_d    = ST_MUTED;
                        ramp_cnt_d = '0;
                    end else if (ramp_wrap) begin
                        shift_d    = shift_q + SHIFT_ONE;
                        ramp_cnt_d = '0;
                        if (shift_q == SHIFT_PRE) begin
                            state_d = ST_MUTED;
                        end
                    end else begin
                        ramp_cnt_d = ramp_cnt_q + RAMP_W'(1);
                    end
                end
                ST_MUTED: begin
                    shift_d = SHIFT_OFF;
                    if (!mute) begin
                        state_d    = ST_RAMP_UP;
                        ramp_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    shift_d    = SHIFT_OFF;
                    ramp_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ramp_cnt_q <= '0;
            shift_q    <= SHIFT_OFF;
        end else begin
            state_q    <= state_d;
            ramp_cnt_q <= ramp_cnt_d;
            shift_q    <= shift_d;
        end
    end

    // ------------------------------------------------------------------
    // Attenuation, offset conversion and first-order modulator
    // ------------------------------------------------------------------
    always_comb begin
        // Shift kept in its own signed assignment so it stays arithmetic.
        shifted   = cur_sample_q >>> shift_q;
        x_eff     = (shift_q == SHIFT_OFF) ? '0 : shifted;
        // MSB inversion maps two's complement onto an unsigned 0..2^W-1
        // range centred at mid-scale.
        u         = {~x_eff[SAMPLE_W-1], x_eff[SAMPLE_W-2:0]};
        sum       = {1'b0, acc_q} + {1'b0, u} + {{SAMPLE_W{1'b0}}, cin};
        acc_d     = sum[SAMPLE_W-1:0];
        c_d       = sum[SAMPLE_W];
        snd_out_d = c_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            s_ready_q      <= 1'b0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            cur_sample_q   <= '0;
            underrun_q     <= 1'b0;
            acc_q          <= '0;
            c_q            <= 1'b0;
            snd_out_q      <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            s_ready_q      <= s_ready_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            cur_sample_q   <= cur_sample_d;
            underrun_q     <= underrun_d;
            acc_q          <= acc_d;
            c_q            <= c_d;
            snd_out_q      <= snd_out_d;
        end
    end

    assign s_if.s_ready = s_ready_q;
    assign snd_out      = snd_out_q;
    assign underrun     = underrun_q;
    assign active       = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_sd_audio_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_audio_out
// Purpose  : Self-checking bench for sd_audio_out with a short sample period
//            and ramp divider so full ramps fit in a short run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_audio_out;

    localparam int SW = 12;
    localparam int P  = 16;
    localparam int R  = 4;

    // Tick n (n >= 1) is applied at clock edge index n*P-1 after reset.
    localparam int RUN_TICK = 1 + SW * R;
    localparam int RUN_EDGE = RUN_TICK * P - 1;

    logic clk;
    logic rst_n;
    logic mute;
    logic snd_out;
    logic underrun;
    logic active;
    int   edges;
    int   tests;
    int   fails;

    sd_audio_out_if #(.SAMPLE_W(SW)) bus ();

    sd_audio_out #(
        .SAMPLE_W      (SW),
        .SAMPLE_PERIOD (P),
        .RAMP_DIV      (R)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_if     (bus),
        .mute     (mute),
        .snd_out  (snd_out),
        .underrun (underrun),
        .active   (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges counted since reset release; edge index k leaves edges == k+1.
    always @(posedge clk) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached (tests=%0d)", tests);
        $fatal(1);
    end

    // ---------------------------------------------------------------
    // Reference model helpers
    // ---------------------------------------------------------------
    function automatic int te(input int n);
        return n * P - 1;
    endfunction

    // Offset-binary modulator input for a 12-bit raw sample at a shift.
    function automatic int u_of(input int raw, input int sh);
        int xs;
        int p;
        xs = (raw >= 2048) ? raw - 4096 : raw;
        if (sh >= SW) return 2048;
        p = 1 << sh;
        if (xs >= 0) xs = xs / p;
        else         xs = -((-xs + p - 1) / p);
        return xs + 2048;
    endfunction

    task automatic do_reset(input logic v, input int data, input logic m);
        @(negedge clk);
        rst_n       = 1'b0;
        bus.s_valid = v;
        bus.s_data  = SW'(data);
        mute        = m;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_edge(input int k);
        while (edges < k + 1) @(negedge clk);
    endtask

    task automatic count_ones(input int n, output int ones);
        ones = 0;
        repeat (n) begin
            @(negedge clk);
            ones += int'(snd_out);
        end
    endtask

    // ---------------------------------------------------------------
    // Tests
    // ---------------------------------------------------------------
    task automatic test_reset();
        rst_n       = 1'b0;
        mute        = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        repeat (2) @(negedge clk);
        tests += 4;
        if (bus.s_ready !== 1'b0) begin fails++; $display("FAIL reset_s_ready got=%b exp=0", bus.s_ready); end
        if (snd_out !== 1'b0) begin fails++; $display("FAIL reset_snd_out got=%b exp=0", snd_out); end
        if (underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
        if (active !== 1'b0) begin fails++; $display("FAIL reset_active got=%b exp=0", active); end
    endtask

    task automatic test_idle_zero();
        int   alt_err, ur_err, act_err, ur_cnt, ur_exp;
        logic prev;
        logic exp_ur;
        alt_err = 0; ur_err = 0; act_err = 0; ur_cnt = 0; ur_exp = 0;
        prev = 1'b0;
        do_reset(1'b0, 0, 1'b0);
        for (int k = 0; k <= RUN_EDGE + 40; k++) begin
            @(negedge clk);
            if (k >= 2 && snd_out === prev) alt_err++;
            prev   = snd_out;
            exp_ur = ((k + 1) % P == 0) && (k >= P - 1);
            if (exp_ur) ur_exp++;
            if (underrun === 1'b1) ur_cnt++;
            if (underrun !== exp_ur) ur_err++;
            if (active !== (k >= RUN_EDGE)) act_err++;
        end
        tests += 4;
        if (alt_err != 0) begin fails++; $display("FAIL idle_alternation breaks=%0d exp=0", alt_err); end
        if (ur_err != 0) begin fails++; $display("FAIL idle_underrun_timing errors=%0d exp=0", ur_err); end
        if (ur_cnt != ur_exp) begin fails++; $display("FAIL idle_underrun_count got=%0d exp=%0d", ur_cnt, ur_exp); end
        if (act_err != 0) begin fails++; $display("FAIL idle_active_timing errors=%0d exp=0 (RUN at edge %0d)", act_err, RUN_EDGE); end
    endtask

    task automatic test_full_scale();
        int   ur_cnt, ones;
        logic exp_rdy;
        ur_cnt = 0;
        do_reset(1'b1, 'h7FF, 1'b0);
        for (int k = 0; k <= RUN_EDGE + 8; k++) begin
            @(negedge clk);
            if (underrun === 1'b1) ur_cnt++;
            if (k == 0 || k == 1 || k == 14 || k == 15 || k == 16) begin
                exp_rdy = (k == 0 || k == 15);
                tests++;
                if (bus.s_ready !== exp_rdy) begin
                    fails++;
                    $display("FAIL full_s_ready edge=%0d got=%b exp=%b", k, bus.s_ready, exp_rdy);
                end
            end
        end
        count_ones(4096, ones);
        tests += 2;
        if (ur_cnt != 0) begin fails++; $display("FAIL full_underrun count=%0d exp=0", ur_cnt); end
        if (ones != u_of('h7FF, 0)) begin fails++; $display("FAIL full_density ones=%0d exp=%0d", ones, u_of('h7FF, 0)); end
    endtask

    task automatic test_density_ramp();
        int n2, ones, expv;
        do_reset(1'b1, 'h400, 1'b0);
        // First tick at which the ramp reaches shift 2.
        n2 = 1 + (SW - 2) * R;
        wait_edge(te(n2) + 5);
        count_ones(32, ones);
        expv = 32 * u_of('h400, 2) / 4096;
        tests++;
        if (ones != expv) begin fails++; $display("FAIL ramp_shift2_density ones=%0d exp=%0d", ones, expv); end
        wait_edge(RUN_EDGE + 8);
        count_ones(4096, ones);
        tests++;
        if (ones != u_of('h400, 0)) begin fails++; $display("FAIL run_0x400_density ones=%0d exp=%0d", ones, u_of('h400, 0)); end
    endtask

    task automatic test_random_run();
        int vals[4];
        int ones, ur_cnt;
        vals[0] = 'h800;
        for (int i = 1; i < 4; i++) vals[i] = int'($urandom_range(0, 4095));
        do_reset(1'b1, vals[0], 1'b0);
        wait_edge(RUN_EDGE + 8);
        for (int i = 0; i < 4; i++) begin
            bus.s_data = SW'(vals[i]);
            repeat (3 * P) @(negedge clk);
            ur_cnt = 0;
            ones   = 0;
            repeat (4096) begin
                @(negedge clk);
                ones += int'(snd_out);
                if (underrun === 1'b1) ur_cnt++;
            end
            tests += 2;
            if (ones != u_of(vals[i], 0)) begin
                fails++;
                $display("FAIL random_density sample=%03h ones=%0d exp=%0d", vals[i], ones, u_of(vals[i], 0));
            end
            if (ur_cnt != 0) begin fails++; $display("FAIL random_underrun count=%0d exp=0", ur_cnt); end
        end
    endtask

    task automatic test_tick_transfer();
        int d, ones;
        d = int'($urandom_range(1, 4095));
        do_reset(1'b0, 0, 1'b0);
        wait_edge(P - 2);
        bus.s_valid = 1'b1;
        bus.s_data  = SW'(d);
        wait_edge(te(1));
        bus.s_valid = 1'b0;
        tests += 2;
        if (underrun !== 1'b0) begin fails++; $display("FAIL tick_xfer_underrun got=%b exp=0", underrun); end
        if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL tick_xfer_s_ready got=%b exp=1", bus.s_ready); end
        wait_edge(te(2));
        tests++;
        if (underrun !== 1'b1) begin fails++; $display("FAIL tick_hold_underrun got=%b exp=1", underrun); end
        wait_edge(RUN_EDGE + 8);
        count_ones(4096, ones);
        tests++;
        if (ones != u_of(d, 0)) begin fails++; $display("FAIL tick_hold_density sample=%03h ones=%0d exp=%0d", d, ones, u_of(d, 0)); end
    endtask

    task automatic test_mute();
        int   x, t_mute, t_unmute, t_run2, t_mute2, t_muted;
        int   alt_err, ur_cnt;
        logic prev;
        x = int'($urandom_range(1, 2047));
        do_reset(1'b1, x, 1'b0);
        wait_edge(RUN_EDGE + 7);
        mute   = 1'b1;
        t_mute = RUN_TICK + 1;
        wait_edge(te(t_mute) - 1);
        tests++;
        if (active !== 1'b1) begin fails++; $display("FAIL mute_active_before got=%b exp=1", active); end
        wait_edge(te(t_mute));
        tests++;
        if (active !== 1'b0) begin fails++; $display("FAIL mute_active_after got=%b exp=0", active); end
        // Shift reaches 5 after five ramp steps; release mute during that step.
        wait_edge(te(t_mute + 5 * R) + 6);
        mute     = 1'b0;
        t_unmute = t_mute + 5 * R + 1;
        t_run2   = t_unmute + 5 * R;
        wait_edge(te(t_run2) - 1);
        tests++;
        if (active !== 1'b0) begin fails++; $display("FAIL resume_active_early got=%b exp=0", active); end
        wait_edge(te(t_run2));
        tests++;
        if (active !== 1'b1) begin fails++; $display("FAIL resume_from_shift5 active=%b exp=1 at tick %0d", active, t_run2); end
        wait_edge(te(t_run2) + 5);
        mute    = 1'b1;
        t_mute2 = t_run2 + 1;
        t_muted = t_mute2 + SW * R;
        ur_cnt  = 0;
        while (edges < te(t_muted) + 6) begin
            @(negedge clk);
            if (underrun === 1'b1) ur_cnt++;
        end
        alt_err = 0;
        prev    = snd_out;
        repeat (200) begin
            @(negedge clk);
            if (snd_out === prev) alt_err++;
            if (underrun === 1'b1) ur_cnt++;
            if (active !== 1'b0) alt_err++;
            prev = snd_out;
        end
        tests += 2;
        if (alt_err != 0) begin fails++; $display("FAIL muted_alternation errors=%0d exp=0", alt_err); end
        if (ur_cnt != 0) begin fails++; $display("FAIL muted_underrun count=%0d exp=0", ur_cnt); end
        mute = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        do_reset(1'b1, 'h7FF, 1'b0);
        wait_edge(te(RUN_TICK + 1) + 1);
        tests++;
        if (bus.s_ready !== 1'b0) begin fails++; $display("FAIL midrst_pending_full s_ready=%b exp=0", bus.s_ready); end
        rst_n = 1'b0;
        @(negedge clk);
        tests += 4;
        if (bus.s_ready !== 1'b0) begin fails++; $display("FAIL midrst_s_ready got=%b exp=0", bus.s_ready); end
        if (snd_out !== 1'b0) begin fails++; $display("FAIL midrst_snd_out got=%b exp=0", snd_out); end
        if (active !== 1'b0) begin fails++; $display("FAIL midrst_active got=%b exp=0", active); end
        if (underrun !== 1'b0) begin fails++; $display("FAIL midrst_underrun got=%b exp=0", underrun); end
        bus.s_valid = 1'b0;
        rst_n       = 1'b1;
        wait_edge(0);
        tests++;
        if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready_after got=%b exp=1", bus.s_ready); end
        wait_edge(te(1));
        tests++;
        if (underrun !== 1'b1) begin fails++; $display("FAIL midrst_pending_dropped underrun=%b exp=1", underrun); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_idle_zero();
        test_full_scale();
        test_density_ramp();
        test_random_run();
        test_tick_transfer();
        test_mute();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sd_audio_out.md
Name: sd_audio_out

Overview:
- Audio output stage sitting directly downstream of the oscillator/sound synthesis block; drives the single-bit audio pin (uio_out[7]) of the VGA+sound demo.
- Paces sample requests from upstream with a valid/ready handshake at a fixed sample rate, holds the last sample on underrun, applies a pop-free shift-based soft ramp on reset/mute, and converts to 1-bit with a first-order sigma-delta modulator.

Parameters:
SAMPLE_W, 12, signed sample width (two's complement)
SAMPLE_PERIOD, 1024, clk cycles per output sample (~24.6 kHz at 25.175 MHz); must be >= 2
RAMP_DIV, 64, sample ticks per ramp step (one shift position)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
s_data  in  SAMPLE_W  signed sample from upstream synth
s_valid  in  1  s_data valid
s_ready  out  1  block can accept a sample
mute  in  1  level; 1 = ramp to silence and hold
snd_out  out  1  registered sigma-delta bitstream
underrun  out  1  one-cycle pulse: tick occurred with no sample received this period
active  out  1  high while in RUN state

Behaviour:
- Reset values: s_ready=0, snd_out=0, underrun=0, active=0, acc=0, cur_sample=0, pending empty, period counter=0, ramp counter=0, shift=SAMPLE_W, state=IDLE.
- Period counter: counts 0..SAMPLE_PERIOD-1, wraps. tick = (count == SAMPLE_PERIOD-1).
- Handshake: s_ready = ~pending_full (registered, 0 during reset). Transfer on s_valid & s_ready -> pending register, pending_full=1. s_data is ignored when s_ready=0.
- At tick: if pending_full, cur_sample <= pending, pending_full <= 0. Else if a transfer occurs in the tick cycle itself, cur_sample <= s_data directly; counts as on time, and pending stays empty. Else cur_sample is held and underrun pulses high on the next cycle.
- s_ready rises again the cycle after the tick that consumed pending.
- Ramp: x_eff = (shift == SAMPLE_W) ? 0 : cur_sample >>> shift (arithmetic). Offset conversion: u = x_eff with MSB inverted.
- FSM updates only on tick, using a ramp counter 0..RAMP_DIV-1:
  - IDLE: on the first tick after reset -> RAMP_UP, or -> MUTED if mute=1.
  - RAMP_UP: on each ramp counter wrap, shift decrements. When shift reaches 0 -> RUN. If mute is sampled high -> RAMP_DOWN from the current shift.
  - RUN: active=1. mute=1 at tick -> RAMP_DOWN.
  - RAMP_DOWN: shift increments per wrap. At SAMPLE_W -> MUTED. mute=0 at tick -> RAMP_UP from the current shift.
  - MUTED: shift=SAMPLE_W. mute=0 at tick -> RAMP_UP.
  - Ramp counter clears on every state change.
- Modulator, every clk: {c, acc} <= acc + u + cin (SAMPLE_W+1-bit sum). snd_out <= c. cin=0 unless the optional feature is enabled.
- Zero sample gives 50% duty: 0,1,0,1...
- Full-scale positive (0x7FF) gives ones except 1 in 4096 zero. Most negative (0x800) gives all zeros.
- Handshake and pending sample continue operating in all states; samples are consumed even while muted.
- Reset mid-operation: all state returns to reset values on the next clk edge, and any pending sample is dropped.

Optional Feature:
SD_AUDIO_DITHER_EN:
- Defined: 16-bit Galois LFSR, seed 0xACE1 at reset, tap mask 0xB400, shifts every clk; its bit0 drives cin. This breaks idle tones. Zero input is no longer a strict 0/1 alternation, but the long-run mean stays within 1/4096 of 50%.
- Undefined: cin=0, no LFSR logic.

Test Plan:
- Reset release, no s_valid, mute=0 (zero sample) -> snd_out strictly alternates 0,1,0,1 from the 2nd cycle. underrun pulses once per 1024 cycles. FSM reaches RUN after 12*64 ticks.
- s_data=0x7FF, s_valid held, after RUN -> over 4096 consecutive cycles snd_out has exactly 4095 ones. s_ready drops 1 cycle after the transfer and rises the cycle after the tick.
- s_data=0x400 in RUN vs RAMP_UP at shift=2 -> ones density 3/4 vs 9/16 (u=0xC00 vs 0x900), measured over 4096 cycles.
- Transfer on exactly the tick cycle with pending empty -> no underrun pulse, and the sample takes effect in the next modulator cycle.
- mute asserted in RUN -> active falls at the next tick; after 12*64 ticks snd_out is a 50% alternation. mute deasserted mid RAMP_DOWN at shift=5 -> RAMP_UP resumes from shift 5.
- rst_n low for 1 cycle mid-RUN with pending_full -> s_ready=0, snd_out=0, state IDLE. Pending is discarded, and the next sample's acceptance restarts from the empty condition.
